register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file_pkg.sv | 20 ++
 rtl/register_file_if.sv | 53 +++++
 rtl/reg_scoreboard.sv | 73 +++++++
 rtl/register_file.sv | 85 ++++++++
 tb/tb_register_file.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/register_file_pkg.sv
// register_file_pkg -- shared processor package for the register file slice.
//
// Holds the default register geometry and the pending-counter type used by the
// RAW scoreboard. Imported by register_file_if, reg_scoreboard and register_file.
//
// Optional feature macro used elsewhere in the slice: REGFILE_BYPASS_EN.

package register_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Per-register count of in-flight writers (saturating 0..3).
  typedef logic [1:0] pend_cnt_t;

  localparam pend_cnt_t PEND_MAX  = 2'd3;
  localparam pend_cnt_t PEND_ZERO = 2'd0;
  localparam pend_cnt_t PEND_ONE  = 2'd1;

endpackage

// File: rtl/register_file_if.sv
// register_file_if -- pipeline-facing bundle of the register file.
//
// Signals:
//   wbData/wbRd/wbRegWrite   write-back port
//   rs1/rs2, rs1Used/rs2Used decode read indices and "really sourced" flags
//   issueValid/issueRd       register-writing instruction leaving decode
//   flush                    squash of every in-flight instruction
//   rs1Data/rs2Data          combinational read data
//   stall                    decode must hold (RAW hazard)
//   sbError                  sticky scoreboard over/underflow flag
//
// Modports: master = pipeline side (drives requests), slave = register file.
//
// Handshake semantics: there is no valid/ready pair here. wbRegWrite,
// issueValid and flush are single-cycle strobes sampled on every rising clk
// edge; the pipeline itself honours stall, so the register file never
// back-pressures a strobe.

interface register_file_if
  import register_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic [DATA_W-1:0] wbData;
  logic [ADDR_W-1:0] wbRd;
  logic              wbRegWrite;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic              rs1Used;
  logic              rs2Used;
  logic              issueValid;
  logic [ADDR_W-1:0] issueRd;
  logic              flush;
  logic [DATA_W-1:0] rs1Data;
  logic [DATA_W-1:0] rs2Data;
  logic              stall;
  logic              sbError;

  modport master (
    output wbData, wbRd, wbRegWrite, rs1, rs2, rs1Used, rs2Used,
           issueValid, issueRd, flush,
    input  rs1Data, rs2Data, stall, sbError
  );

  modport slave (
    input  wbData, wbRd, wbRegWrite, rs1, rs2, rs1Used, rs2Used,
           issueValid, issueRd, flush,
    output rs1Data, rs2Data, stall, sbError
  );

endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard -- per-register pending-writer counters for RAW detection.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   issueValid, issueRd   increment the destination's counter
//   wbRegWrite, wbRd      decrement the destination's counter
//   flush                 clear every counter at the next edge
//   busy[i]               counter i is non-zero
//   busyOne[i]            counter i is exactly one (last writer in flight)
//   sbError               sticky over/underflow flag
//
// Index 0 never counts. Issue and retire to the same index in one cycle
// cancel out. A flush cycle does not evaluate over/underflow because every
// count is being discarded anyway.

module reg_scoreboard
  import register_file_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issueValid,
  input  logic [ADDR_W-1:0]        issueRd,
  input  logic                     wbRegWrite,
  input  logic [ADDR_W-1:0]        wbRd,
  input  logic                     flush,
  output logic [(1<<ADDR_W)-1:0]   busy,
  output logic [(1<<ADDR_W)-1:0]   busyOne,
  output logic                     sbError
);

  localparam int NREG = 1 << ADDR_W;

  pend_cnt_t       cnt [NREG];
  logic [NREG-1:0] inc;
  logic [NREG-1:0] dec;
  logic            errNow;

  always_comb begin
    inc     = '0;
    dec     = '0;
    errNow  = 1'b0;
    busy    = '0;
    busyOne = '0;
    for (int i = 1; i < NREG; i++) begin
      inc[i]     = issueValid && (issueRd == ADDR_W'(i));
      dec[i]     = wbRegWrite && (wbRd == ADDR_W'(i));
      busy[i]    = (cnt[i] != PEND_ZERO);
      busyOne[i] = (cnt[i] == PEND_ONE);
      if (inc[i] && !dec[i] && cnt[i] == PEND_MAX)  errNow = 1'b1;
      if (dec[i] && !inc[i] && cnt[i] == PEND_ZERO) errNow = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= PEND_ZERO;
      sbError <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= PEND_ZERO;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (inc[i] && !dec[i] && cnt[i] != PEND_MAX)
          cnt[i] <= cnt[i] + 2'd1;
        else if (dec[i] && !inc[i] && cnt[i] != PEND_ZERO)
          cnt[i] <= cnt[i] - 2'd1;
      end
      if (errNow) sbError <= 1'b1;
    end
  end

endmodule

// File: rtl/register_file.sv
// register_file -- 2-read / 1-write register file with RAW-hazard scoreboard.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset (clears storage, counters, sbError)
//   rf      register_file_if.slave: write-back, decode reads, issue, flush,
//           read data, stall and sbError
//
// Storage and the optional write-back bypass live here; the pending counters
// live in reg_scoreboard.
//
// Build option REGFILE_BYPASS_EN: a read of the register being written back
// this cycle returns wbData, and a last in-flight writer retiring this cycle
// does not stall. Without it, reads return stored contents only and stall
// clears one cycle after the write-back.

module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic           clk,
  input  logic           rst_n,
  register_file_if.slave rf
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busyOne;
  logic              wbLive;
  logic [DATA_W-1:0] rs1Val;
  logic [DATA_W-1:0] rs2Val;
  logic              rs1Wait;
  logic              rs2Wait;

  reg_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .issueValid (rf.issueValid),
    .issueRd    (rf.issueRd),
    .wbRegWrite (rf.wbRegWrite),
    .wbRd       (rf.wbRd),
    .flush      (rf.flush),
    .busy       (busy),
    .busyOne    (busyOne),
    .sbError    (rf.sbError)
  );

  assign wbLive = rf.wbRegWrite && (rf.wbRd != '0);

  // regs[0] is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wbLive) begin
      regs[rf.wbRd] <= rf.wbData;
    end
  end

  always_comb begin
    rs1Val  = (rf.rs1 == '0) ? '0 : regs[rf.rs1];
    rs2Val  = (rf.rs2 == '0) ? '0 : regs[rf.rs2];
    rs1Wait = rf.rs1Used && (rf.rs1 != '0) && busy[rf.rs1];
    rs2Wait = rf.rs2Used && (rf.rs2 != '0) && busy[rf.rs2];
`ifdef REGFILE_BYPASS_EN
    // Forwarding is gated by rst_n so reads are zero while reset is held.
    if (rst_n && wbLive && rf.wbRd == rf.rs1) rs1Val = rf.wbData;
    if (rst_n && wbLive && rf.wbRd == rf.rs2) rs2Val = rf.wbData;
    // The final outstanding writer is delivering its value right now.
    if (wbLive && rf.wbRd == rf.rs1 && busyOne[rf.rs1]) rs1Wait = 1'b0;
    if (wbLive && rf.wbRd == rf.rs2 && busyOne[rf.rs2]) rs2Wait = 1'b0;
`else
    // busyOne only matters when forwarding is built in.
    if (busyOne[0]) rs1Wait = rs1Wait;
`endif
  end

  assign rf.rs1Data = rs1Val;
  assign rf.rs2Data = rs2Val;
  assign rf.stall   = rs1Wait || rs2Wait;

endmodule

// File: tb/tb_register_file.sv
// tb_register_file -- self-checking bench for register_file.
//
// Directed scenarios (reset, write/read, x0, RAW stall and release, same-cycle
// issue/retire, counter saturation and sticky error, flush, mid-cycle reset)
// followed by random traffic, all compared against an array-based reference
// model of architectural values and pending-writer counts.
// Honours REGFILE_BYPASS_EN in the expected-value functions.

`timescale 1ns/1ps

module tb_register_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 1 << AW;

  logic clk;
  logic rst_n;

  register_file_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  register_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [DW-1:0] mem [NR];
  int            pend [NR];
  bit            errM;

  int checks = 0;
  int errors = 0;

  task automatic model_clear();
    for (int i = 0; i < NR; i++) begin
      mem[i]  = '0;
      pend[i] = 0;
    end
    errM = 1'b0;
  endtask

  // Applies one rising edge worth of architectural effects.
  task automatic model_update();
    if (bus.flush) begin
      for (int i = 0; i < NR; i++) pend[i] = 0;
    end else begin
      for (int i = 1; i < NR; i++) begin
        bit inc, dec;
        inc = bus.issueValid && (int'(bus.issueRd) == i);
        dec = bus.wbRegWrite && (int'(bus.wbRd) == i);
        if (inc && !dec) begin
          if (pend[i] == 3) errM = 1'b1;
          else pend[i] = pend[i] + 1;
        end else if (dec && !inc) begin
          if (pend[i] == 0) errM = 1'b1;
          else pend[i] = pend[i] - 1;
        end
      end
    end
    if (bus.wbRegWrite && bus.wbRd != 0) mem[bus.wbRd] = bus.wbData;
  endtask

  function automatic logic [DW-1:0] exp_read(logic [AW-1:0] idx);
    if (idx == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (bus.wbRegWrite && bus.wbRd == idx) return bus.wbData;
`endif
    return mem[idx];
  endfunction

  function automatic bit exp_pending(logic [AW-1:0] idx);
    if (idx == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (pend[idx] == 1 && bus.wbRegWrite && bus.wbRd == idx) return 1'b0;
`endif
    return pend[idx] > 0;
  endfunction

  function automatic bit exp_stall();
    return (bus.rs1Used && exp_pending(bus.rs1)) ||
           (bus.rs2Used && exp_pending(bus.rs2));
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(string tag);
    chk({tag, ".rs1Data"}, bus.rs1Data, exp_read(bus.rs1));
    chk({tag, ".rs2Data"}, bus.rs2Data, exp_read(bus.rs2));
    chk({tag, ".stall"},   {31'd0, bus.stall},   {31'd0, exp_stall()});
    chk({tag, ".sbError"}, {31'd0, bus.sbError}, {31'd0, errM});
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.wbData     = '0;
    bus.wbRd       = '0;
    bus.wbRegWrite = 1'b0;
    bus.rs1        = '0;
    bus.rs2        = '0;
    bus.rs1Used    = 1'b0;
    bus.rs2Used    = 1'b0;
    bus.issueValid = 1'b0;
    bus.issueRd    = '0;
    bus.flush      = 1'b0;
  endtask

  task automatic wb(logic [AW-1:0] rd, logic [DW-1:0] d);
    bus.wbRegWrite = 1'b1;
    bus.wbRd       = rd;
    bus.wbData     = d;
  endtask

  task automatic issue(logic [AW-1:0] rd);
    bus.issueValid = 1'b1;
    bus.issueRd    = rd;
  endtask

  task automatic rd1(logic [AW-1:0] r, logic u);
    bus.rs1     = r;
    bus.rs1Used = u;
  endtask

  task automatic rd2(logic [AW-1:0] r, logic u);
    bus.rs2     = r;
    bus.rs2Used = u;
  endtask

  // Inputs are driven just after a falling edge; settle checks them.
  task automatic settle(string tag);
    #1;
    check_outputs(tag);
  endtask

  // Clocks the DUT and the model, returning just after the next falling edge.
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    settle("reset");
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    model_clear();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rd1(5, 1'b1);
    rd2(9, 1'b1);
    settle("reset_state");
    chk("reset_rs1Data", bus.rs1Data, 32'h0);
    rst_n = 1'b1;

    // Write x5 then read it back; x0 ignores writes.
    idle(); wb(5, 32'hDEADBEEF);
    settle("wr_x5"); tick();
    idle(); rd1(5, 1'b0); wb(0, 32'h1234);
    settle("rd_x5");
    chk("x5_readback", bus.rs1Data, 32'hDEADBEEF);
    tick();
    idle(); rd2(0, 1'b0);
    settle("rd_x0");
    chk("x0_reads_zero", bus.rs2Data, 32'h0);
    tick();

    // RAW hazard on x7.
    do_reset();
    idle(); issue(7);
    settle("iss_x7"); tick();
    idle(); rd1(7, 1'b1);
    settle("raw_x7_a");
    chk("raw_x7_stall_a", {31'd0, bus.stall}, 32'd1);
    tick();
    settle("raw_x7_b");
    chk("raw_x7_stall_b", {31'd0, bus.stall}, 32'd1);
    tick();
    wb(7, 32'hCAFE0007);
    settle("raw_x7_wb");
`ifdef REGFILE_BYPASS_EN
    chk("raw_x7_wb_stall", {31'd0, bus.stall}, 32'd0);
    chk("raw_x7_wb_data",  bus.rs1Data, 32'hCAFE0007);
`else
    chk("raw_x7_wb_stall", {31'd0, bus.stall}, 32'd1);
    chk("raw_x7_wb_data",  bus.rs1Data, 32'h0);
`endif
    tick();
    bus.wbRegWrite = 1'b0;
    settle("raw_x7_after");
    chk("raw_x7_after_stall", {31'd0, bus.stall}, 32'd0);
    chk("raw_x7_after_data",  bus.rs1Data, 32'hCAFE0007);
    tick();

    // Issue and retire x3 in the same cycle with one writer in flight.
    idle(); issue(3);
    settle("iss_x3"); tick();
    idle(); issue(3); wb(3, 32'h33); rd2(3, 1'b1);
    settle("x3_same_cycle"); tick();
    idle(); rd2(3, 1'b1);
    settle("x3_after");
    chk("x3_still_stall", {31'd0, bus.stall}, 32'd1);
    tick();

    // Counter saturation on x9, sticky error.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      idle(); issue(9);
      settle("iss_x9"); tick();
      idle();
      #1;
      chk($sformatf("sbError_after_issue%0d", k + 1), {31'd0, bus.sbError},
          (k == 3) ? 32'd1 : 32'd0);
    end
    for (int k = 0; k < 3; k++) begin
      idle(); rd1(9, 1'b1); wb(9, $urandom);
      settle("wb_x9"); tick();
    end
    idle(); rd1(9, 1'b1);
    settle("x9_drained");
    chk("x9_drained_stall", {31'd0, bus.stall}, 32'd0);
    wb(10, 32'h10);
    settle("wb_x10_underflow"); tick();
    idle();
    settle("sticky");
    chk("sbError_sticky", {31'd0, bus.sbError}, 32'd1);

    // Flush overrides a simultaneous issue.
    do_reset();
    idle(); issue(4); settle("iss_x4"); tick();
    idle(); issue(6); settle("iss_x6"); tick();
    idle(); issue(8); bus.flush = 1'b1; wb(6, 32'h66);
    settle("flush"); tick();
    idle(); rd1(8, 1'b1); rd2(4, 1'b1);
    settle("post_flush_a");
    chk("post_flush_stall_a", {31'd0, bus.stall}, 32'd0);
    rd2(6, 1'b1);
    settle("post_flush_b");
    chk("post_flush_stall_b", {31'd0, bus.stall}, 32'd0);
    chk("flush_cycle_write", bus.rs2Data, 32'h66);
    tick();

    // Reset asserted mid-cycle during a write of x2.
    idle(); issue(2); settle("iss_x2a"); tick();
    idle(); issue(2); settle("iss_x2b"); tick();
    idle(); wb(11, 32'h11); settle("wb_x11"); tick();
    idle(); wb(2, 32'h22222222); rd1(2, 1'b1); rd2(11, 1'b1);
    settle("pre_reset");
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    check_outputs("mid_reset");
    chk("mid_reset_sbError", {31'd0, bus.sbError}, 32'd0);
    chk("mid_reset_stall",   {31'd0, bus.stall},   32'd0);
    @(posedge clk);
    @(negedge clk);
    settle("reset_held");
    chk("reset_held_x2", bus.rs1Data, 32'h0);
    rst_n = 1'b1;
    idle(); rd1(2, 1'b1);
    settle("after_reset");
    chk("after_reset_x2", bus.rs1Data, 32'h0);
    tick();

    // Random traffic over a small index window so hazards collide often.
    for (int n = 0; n < 400; n++) begin
      idle();
      rd1(AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      rd2(AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) issue(AW'($urandom_range(0, 7)));
      if ($urandom_range(0, 2) != 0) wb(AW'($urandom_range(0, 7)), $urandom);
      bus.flush = ($urandom_range(0, 24) == 0);
      settle($sformatf("rand%0d", n));
      tick();
    end

    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
